// File: rtl/spy_playback_controller.sv
// Spy buffer playback controller: gates recording into the circular memory,
// freezes it on request and streams the stored words oldest-first.
module spy_playback_controller #(
  parameter int WIDTH     = 6,
  parameter int DATAWIDTH = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 freeze,
  input  logic                 unfreeze,
  input  logic                 playback_start,
  output logic                 mem_write_enable,
  input  logic [WIDTH-1:0]     mem_write_pointer,
  output logic [WIDTH-1:0]     mem_read_addr,
  output logic                 mem_read_enable,
  input  logic [DATAWIDTH-1:0] mem_read_data,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 frozen,
  output logic                 done,
  output logic [WIDTH:0]       fill_count
);

  localparam logic [WIDTH:0] SIZE = (WIDTH + 1)'(1) << WIDTH;

  typedef enum logic [1:0] {RECORD, FROZEN, PLAYBACK} state_t;

  state_t               state;
  logic [WIDTH:0]       reads_left;
  logic                 empty_playback;
  logic [WIDTH-1:0]     read_addr;
  logic                 in_flight;
  logic                 in_flight_last;
  logic [DATAWIDTH-1:0] fifo_data [2];
  logic [1:0]           fifo_last;
  logic                 head;
  logic                 tail;
  logic [1:0]           fifo_count;
  logic                 pop;
  logic                 issue;
  logic [2:0]           committed;

  assign pop = (fifo_count != 2'd0) && out_ready;
  // Slots still claimed after this cycle's pop; a new read only fits below two.
  assign committed = {1'b0, fifo_count} - {2'b00, pop} + {2'b00, in_flight};
  assign issue = (state == PLAYBACK) && (reads_left != '0) && (committed < 3'd2);

  assign mem_write_enable = (state == RECORD) && in_valid && !reset;
  assign mem_read_enable  = issue;
  assign mem_read_addr    = read_addr;
  assign out_valid        = (fifo_count != 2'd0);
  assign out_data         = fifo_data[head];
  assign out_last         = out_valid && fifo_last[head];
  assign frozen           = (state != RECORD);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= RECORD;
      reads_left     <= '0;
      empty_playback <= 1'b0;
      read_addr      <= '0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
      for (int i = 0; i < 2; i++) fifo_data[i] <= '0;
      fifo_last      <= 2'b00;
      head           <= 1'b0;
      tail           <= 1'b0;
      fifo_count     <= 2'd0;
      done           <= 1'b0;
      fill_count     <= '0;
    end else begin
      done           <= 1'b0;
      in_flight      <= issue;
      in_flight_last <= issue && (reads_left == (WIDTH + 1)'(1));

      if (pop) head <= ~head;
      if (in_flight) begin
        fifo_data[tail] <= mem_read_data;
        fifo_last[tail] <= in_flight_last;
        tail            <= ~tail;
      end
      case ({in_flight, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase

      case (state)
        RECORD: begin
          if (in_valid && (fill_count != SIZE)) fill_count <= fill_count + (WIDTH + 1)'(1);
          if (freeze) state <= FROZEN;
        end
        FROZEN: begin
          if (playback_start) begin
            state          <= PLAYBACK;
            reads_left     <= fill_count;
            empty_playback <= (fill_count == '0);
            // Dropping the top bit makes a full buffer start at the write pointer.
            read_addr      <= mem_write_pointer - fill_count[WIDTH-1:0];
          end else if (unfreeze) begin
            state <= RECORD;
          end
        end
        PLAYBACK: begin
          if (issue) begin
            read_addr  <= read_addr + WIDTH'(1);
            reads_left <= reads_left - (WIDTH + 1)'(1);
          end
          if (empty_playback || (pop && fifo_last[head])) begin
            done  <= 1'b1;
            state <= FROZEN;
          end
        end
        default: state <= RECORD;
      endcase
    end
  end

endmodule
